// File: rtl/syn_cortex_lb_slave.sv
// Cortex local-bus Avalon-MM responder: ID/scratch/status/ctrl register bank.
// Define SYN_CORTEX_LB_SLAVE_ERR_EN for DEAD_BEEF miss reads plus a miss counter.
module syn_cortex_lb_slave #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter logic [3:0]        BLK_ID   = 4'h0,
    parameter int                NUM_REGS = 8,
    parameter int                RD_LAT   = 2,
    parameter logic [DATA_W-1:0] ID_VAL   = 32'h5359_4E00
) (
    input  logic                           av_clk,
    input  logic                           av_rst,
    input  logic                           av_read,
    input  logic                           av_write,
    input  logic [ADDR_W-1:0]              av_addr,
    input  logic [DATA_W-1:0]              av_write_data,
    output logic                           av_wait_req,
    output logic [DATA_W-1:0]              av_read_data,
    output logic                           av_read_data_valid,
    input  logic [DATA_W-1:0]              status_in,
    output logic [(NUM_REGS-3)*DATA_W-1:0] ctrl_regs
);

    localparam int IDX_W    = ADDR_W - 4;
    localparam int NUM_CTRL = NUM_REGS - 3;
    localparam int CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

`ifdef SYN_CORTEX_LB_SLAVE_ERR_EN
    localparam bit                ERR_EN   = 1'b1;
    localparam logic [DATA_W-1:0] MISS_VAL = DATA_W'(32'hDEAD_BEEF);
`else
    localparam bit                ERR_EN   = 1'b0;
    localparam logic [DATA_W-1:0] MISS_VAL = '0;
`endif

    typedef enum logic {
        IDLE,
        RDWAIT
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    lat_cnt;
    logic [DATA_W-1:0]   scratch;
    logic [DATA_W-1:0]   ctrl_q [NUM_CTRL];
    logic [DATA_W-1:0]   word_q;
    logic [DATA_W-1:0]   rd_word;
    logic [IDX_W-1:0]    idx;
    logic                hit;
    logic                accept;
    logic                wr_acc;
    logic                rd_acc;

    assign idx    = av_addr[IDX_W-1:0];
    assign hit    = (av_addr[ADDR_W-1 -: 4] == BLK_ID)
                 && (idx < IDX_W'(NUM_REGS));
    assign accept = (av_read | av_write) & ~av_wait_req;
    assign wr_acc = accept & av_write;
    assign rd_acc = accept & av_read & ~av_write;

`ifdef SYN_CORTEX_LB_SLAVE_ERR_EN
    logic [15:0] miss_cnt;

    always_ff @(posedge av_clk or posedge av_rst) begin
        if (av_rst) begin
            miss_cnt <= '0;
        end else if (accept && !hit) begin
            if (miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
        end else if (wr_acc && idx == IDX_W'(0)) begin
            miss_cnt <= '0;
        end
    end
`endif

    always_comb begin
        rd_word = MISS_VAL;
        if (hit) begin
            rd_word = '0;
            unique case (1'b1)
                idx == IDX_W'(0): rd_word = ID_VAL;
                idx == IDX_W'(1): rd_word = scratch;
                idx == IDX_W'(2): rd_word = status_in;
                default: begin
                    for (int i = 0; i < NUM_CTRL; i++)
                        if (idx == IDX_W'(i + 3))
                            rd_word = ctrl_q[i];
`ifdef SYN_CORTEX_LB_SLAVE_ERR_EN
                    if (idx == IDX_W'(NUM_REGS - 1))
                        rd_word = DATA_W'(miss_cnt);
`endif
                end
            endcase
        end
    end

    always_ff @(posedge av_clk or posedge av_rst) begin
        if (av_rst) begin
            state              <= IDLE;
            lat_cnt            <= '0;
            av_wait_req        <= 1'b0;
            av_read_data       <= '0;
            av_read_data_valid <= 1'b0;
            word_q             <= '0;
            scratch            <= '0;
            for (int i = 0; i < NUM_CTRL; i++)
                ctrl_q[i] <= '0;
        end else begin
            av_read_data_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (wr_acc && hit) begin
                        if (idx == IDX_W'(1))
                            scratch <= av_write_data;
                        // Top ctrl slot is the read-only miss counter when enabled
                        for (int i = 0; i < NUM_CTRL; i++)
                            if (idx == IDX_W'(i + 3)
                                && !(ERR_EN && i == NUM_CTRL - 1))
                                ctrl_q[i] <= av_write_data;
                    end else if (rd_acc) begin
                        if (RD_LAT == 1) begin
                            av_read_data       <= rd_word;
                            av_read_data_valid <= 1'b1;
                        end else begin
                            word_q      <= rd_word;
                            lat_cnt     <= CNT_W'(RD_LAT - 1);
                            av_wait_req <= 1'b1;
                            state       <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    if (lat_cnt == CNT_W'(1)) begin
                        av_read_data       <= word_q;
                        av_read_data_valid <= 1'b1;
                        av_wait_req        <= 1'b0;
                        lat_cnt            <= '0;
                        state              <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
        assign ctrl_regs[g*DATA_W +: DATA_W] = ctrl_q[g];
    end

endmodule

// File: tb/tb_syn_cortex_lb_slave.sv
// Bench for syn_cortex_lb_slave: vector table plus scoreboard of read responses.
// Build with SYN_CORTEX_LB_SLAVE_ERR_EN to exercise the miss-counter variant.
module tb_syn_cortex_lb_slave;

    localparam int RD_LAT = 2;
    localparam logic [31:0] ID = 32'h5359_4E00;

`ifdef SYN_CORTEX_LB_SLAVE_ERR_EN
    localparam logic [31:0] MISS   = 32'hDEAD_BEEF;
    localparam logic [31:0] CNT7_A = 32'd1;
    localparam logic [31:0] CNT7_B = 32'd2;
    localparam logic [159:0] CTRL_EXP =
        {32'd0, 32'd4, 32'd3, 32'd2, 32'd1};
`else
    localparam logic [31:0] MISS   = 32'h0;
    localparam logic [31:0] CNT7_A = 32'd0;
    localparam logic [31:0] CNT7_B = 32'd5;
    localparam logic [159:0] CTRL_EXP =
        {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
`endif

    logic         av_clk = 1'b0;
    logic         av_rst = 1'b1;
    logic         av_read = 1'b0;
    logic         av_write = 1'b0;
    logic [15:0]  av_addr = '0;
    logic [31:0]  av_write_data = '0;
    logic         av_wait_req;
    logic [31:0]  av_read_data;
    logic         av_read_data_valid;
    logic [31:0]  status_in = '0;
    logic [159:0] ctrl_regs;

    syn_cortex_lb_slave #(.RD_LAT(RD_LAT)) dut (
        .av_clk             (av_clk),
        .av_rst             (av_rst),
        .av_read            (av_read),
        .av_write           (av_write),
        .av_addr            (av_addr),
        .av_write_data      (av_write_data),
        .av_wait_req        (av_wait_req),
        .av_read_data       (av_read_data),
        .av_read_data_valid (av_read_data_valid),
        .status_in          (status_in),
        .ctrl_regs          (ctrl_regs)
    );

    always #5 av_clk = ~av_clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] status;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb_data[$];
    int          sb_acc[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_valid = 0;

    always @(posedge av_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] act,
                         input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge av_clk) begin
        if (!av_rst && av_read_data_valid) begin
            n_valid++;
            if (sb_data.size() == 0) begin
                check("unexpected_valid", 1'b1, 1'b0);
            end else begin
                check("rd_data", av_read_data, sb_data.pop_front());
                check("rd_latency", cyc - sb_acc.pop_front(), RD_LAT - 1);
            end
        end
    end

    task automatic apply(input vec_t v);
        int n;
        @(negedge av_clk);
        av_read       = v.rd;
        av_write      = v.wr;
        av_addr       = v.addr;
        av_write_data = v.wdata;
        status_in     = v.status;
        n = 0;
        while (av_wait_req && n < 20) begin
            @(negedge av_clk);
            n++;
        end
        if (v.wr)
            check("wr_no_wait", av_wait_req, 1'b0);
        if (v.rd && !v.wr) begin
            sb_data.push_back(v.exp);
            sb_acc.push_back(cyc + 1);
        end
        @(posedge av_clk);
        #1;
        av_read   = 1'b0;
        av_write  = 1'b0;
        status_in = '0;
        if (v.rd && !v.wr) begin
            @(negedge av_clk);
            check("wait_req_hi", av_wait_req, 1'b1);
            n = 0;
            while (sb_data.size() != 0 && n < 20) begin
                @(negedge av_clk);
                n++;
            end
            if (sb_data.size() != 0) begin
                check("rd_timeout", 1'b1, 1'b0);
                sb_data.delete();
                sb_acc.delete();
            end
        end
    endtask

    initial begin
        tbl.push_back('{1, 0, 16'h0000, 0, 0, ID});
        tbl.push_back('{0, 1, 16'h0001, 32'hA5A5_1234, 0, 0});
        tbl.push_back('{1, 0, 16'h0001, 0, 0, 32'hA5A5_1234});
        tbl.push_back('{0, 1, 16'h0000, 32'hFFFF_FFFF, 0, 0});
        tbl.push_back('{1, 0, 16'h0000, 0, 0, ID});
        tbl.push_back('{0, 1, 16'h0002, 32'h1, 0, 0});
        tbl.push_back('{1, 0, 16'h0002, 0, 32'h0000_00FF, 32'h0000_00FF});
        tbl.push_back('{1, 0, 16'h1001, 0, 0, MISS});
        tbl.push_back('{1, 0, 16'h0007, 0, 0, CNT7_A});
        tbl.push_back('{0, 1, 16'h0003, 32'd1, 0, 0});
        tbl.push_back('{0, 1, 16'h0004, 32'd2, 0, 0});
        tbl.push_back('{0, 1, 16'h0005, 32'd3, 0, 0});
        tbl.push_back('{0, 1, 16'h0006, 32'd4, 0, 0});
        tbl.push_back('{0, 1, 16'h0007, 32'd5, 0, 0});
        tbl.push_back('{1, 0, 16'h0003, 0, 0, 32'd1});
        tbl.push_back('{1, 0, 16'h0008, 0, 0, MISS});
        tbl.push_back('{1, 0, 16'h0007, 0, 0, CNT7_B});
        tbl.push_back('{1, 1, 16'h0001, 32'h77, 0, 0});
        tbl.push_back('{1, 0, 16'h0001, 0, 0, 32'h77});

        repeat (3) @(negedge av_clk);
        check("rst_wait_req", av_wait_req, 1'b0);
        check("rst_rdata", av_read_data, 32'h0);
        check("rst_valid", av_read_data_valid, 1'b0);
        check("rst_ctrl", ctrl_regs, 160'h0);
        av_rst = 1'b0;
        repeat (2) @(negedge av_clk);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        check("ctrl_regs", ctrl_regs, CTRL_EXP);
        check("rdata_hold", av_read_data, 32'h77);

        // Reset one cycle after a read accept must swallow the response
        @(negedge av_clk);
        av_read = 1'b1;
        av_addr = 16'h0000;
        @(posedge av_clk);
        #1;
        av_read = 1'b0;
        @(negedge av_clk);
        av_rst = 1'b1;
        sb_data.delete();
        sb_acc.delete();
        n_valid = 0;
        @(negedge av_clk);
        check("mid_rst_wait", av_wait_req, 1'b0);
        check("mid_rst_rdata", av_read_data, 32'h0);
        check("mid_rst_valid", av_read_data_valid, 1'b0);
        check("mid_rst_ctrl", ctrl_regs, 160'h0);
        av_rst = 1'b0;
        repeat (6) @(negedge av_clk);
        check("no_valid_after_rst", n_valid, 0);

        apply('{1, 0, 16'h0001, 0, 0, 32'h0});
        apply('{1, 0, 16'h0000, 0, 0, ID});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/syn_cortex_lb_slave.md
Name: syn_cortex_lb_slave

Overview:
Avalon-MM local-bus responder: the slave end of the cortex local bus, driven by the testbench or CPU-side master. It decodes the block select in the upper address bits and serves a small register bank (ID, scratch, status, control). Reads return after a fixed, parameterised latency with one read outstanding at a time. Control registers are exported to the datapath, and a status word is imported from it.

Parameters:
ADDR_W, 16, av_addr width; [ADDR_W-1:ADDR_W-4] = block select, [ADDR_W-5:0] = register index
DATA_W, 32, data width
BLK_ID, 4'h0, block select value this slave responds to
NUM_REGS, 8, register count (>=4); index 0 ID, 1 scratch, 2 status, 3..NUM_REGS-1 control
RD_LAT, 2, read latency in cycles from accept to av_read_data_valid (>=1)
ID_VAL, 32'h5359_4E00, constant returned at index 0

Ports:
av_clk  input  1  clock
av_rst  input  1  asynchronous, active-high reset
av_read  input  1  1 -> read request
av_write  input  1  1 -> write request
av_addr  input  ADDR_W  address
av_write_data  input  DATA_W  write data
av_wait_req  output  1  1 -> master must hold the request
av_read_data  output  DATA_W  read data
av_read_data_valid  output  1  1 -> av_read_data valid, one-cycle pulse
status_in  input  DATA_W  datapath status, sampled at read accept
ctrl_regs  output  (NUM_REGS-3)*DATA_W  control registers; reg 3 in the LSBs

Behaviour:
- Reset (async, av_rst=1): av_wait_req=0, av_read_data=0, av_read_data_valid=0, scratch=0, all ctrl_regs=0, FSM=IDLE, latency counter=0.
- Acceptance: a request is accepted on a rising edge where (av_read|av_write)=1 and av_wait_req=0. av_wait_req is registered.
- Hit: addr[ADDR_W-1:ADDR_W-4]==BLK_ID and index<NUM_REGS. All other addresses are a miss.
- FSM IDLE:
  - Accepted write: on a hit to index 1 or to index 3..NUM_REGS-1, the register updates at that edge. Writes to index 0 or 2, or misses, are dropped. FSM stays IDLE; av_wait_req stays 0, so back-to-back writes run at one per cycle.
  - Accepted read: capture the read word (ID_VAL, scratch, status_in as sampled at this edge, ctrl, or the miss value). Set av_wait_req=1 and load counter=RD_LAT-1. Go to RDWAIT.
  - av_read and av_write both high: the write is performed and the read is ignored (protocol violation; no response is generated).
- FSM RDWAIT: hold av_wait_req=1; decrement the counter each cycle. When the counter is 0: drive av_read_data=captured word, pulse av_read_data_valid=1 for one cycle, deassert av_wait_req on the same edge, and go to IDLE.
- Timing: a read accepted at edge T produces valid in the cycle after edge T+RD_LAT-1 (RD_LAT cycles after accept). av_wait_req is high in cycles T+1..T+RD_LAT-1 and is not raised when RD_LAT=1.
- A new request may be accepted in the same cycle that valid is high.
- av_read_data holds its last value when valid=0.
- Miss read returns 0 (see optional feature).
- Reset asserted mid-read: the pending response is discarded and no valid is produced after reset release.

Optional Feature:
SYN_CORTEX_LB_SLAVE_ERR_EN
- Defined: a miss read returns 32'hDEAD_BEEF. A saturating 16-bit miss counter increments on every miss (read or write). The counter is readable at index NUM_REGS-1 in bits [15:0], which makes that index read-only (its ctrl slice is forced to 0). Writing any value to index 0 clears the counter.
- Undefined: a miss read returns 0, no counter exists, and index NUM_REGS-1 is an ordinary control register.

Test Plan:
1. Reset, then read index 0 with BLK_ID match -> valid exactly RD_LAT=2 cycles after accept, data 32'h5359_4E00; av_wait_req high for 1 cycle.
2. Write 32'hA5A5_1234 to scratch, then read it back -> 32'hA5A5_1234. Write to index 0, then read it -> still ID_VAL.
3. Back-to-back writes to ctrl indices 3..7 with values 1..5 -> ctrl_regs shows 1..5 in order, av_wait_req never asserted.
4. status_in=32'h0000_00FF at accept, changed to 0 one cycle later -> read returns 32'h0000_00FF.
5. Read with block select != BLK_ID -> data 0 (ERR_EN off) or 32'hDEAD_BEEF with the miss counter at 1 (ERR_EN on).
6. Assert av_rst one cycle after a read accept -> no av_read_data_valid pulse follows; all outputs are 0 and ctrl_regs are 0.
